cla_share_sched: RTL and testbench

- Scheduler that time-shares one 16-bit carry-lookahead add/subtract datapath between NUM_REQ requesters (e.g. the ALU and the address unit).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A round-robin arbiter grants one operation at a time.
- Operands are registered into the shared adder and the result is held until the owner consumes it.

---
 rtl/cla_share_pkg.sv | 22 ++
 rtl/cla16.sv | 46 ++++
 rtl/rr_arb.sv | 30 +++
 rtl/cla_share_sched.sv | 135 +++++++++++++
 tb/tb_cla_share_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cla_share_pkg.sv
// Shared types and constants for the cla_share_sched scheduler: FSM encoding,
// default geometry and the saturation limits used by the optional clamp.
package cla_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NUM_REQ = 2;

    localparam logic [DEF_WIDTH-1:0] SAT_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    // Width of a requester index; never zero so a single requester still gets a bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla16.sv
// Carry-lookahead adder: 4-bit lookahead groups chained through group
// generate/propagate terms. WIDTH must be a multiple of 4 (16 by default).
module cla16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] g, p, c;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      gc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        c     = '0;
        gg    = '0;
        gp    = '0;
        gc    = '0;
        gc[0] = cin_i;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j]     = &p[4*j +: 4];
            gc[j+1]   = gg[j] | (gp[j] & gc[j]);
            c[4*j]    = gc[j];
            c[4*j+1]  = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2]  = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3]  = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                      | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign sum_o  = p ^ c;
    assign cout_o = gc[NG];

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: the requester just after ptr_i has top
// priority, wrapping; the pointer itself is owned by the parent.
module rr_arb
    import cla_share_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PW      = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    // Walk from lowest to highest priority so the last match wins.
    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_i[i] && (i == ((int'(ptr_i) + k) % NUM_REQ))) begin
                        gnt_o    = '0;
                        gnt_o[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cla_share_sched.sv
// Time-shares one CLA add/subtract datapath between NUM_REQ requesters.
// Define CLA_SHARE_SCHED_SAT_EN to clamp overflowing results to SAT_POS/SAT_NEG.
module cla_share_sched
    import cla_share_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_ovfl,
    output logic                     rsp_zero,
    output logic                     busy
);
    localparam int PW  = ptr_w(NUM_REQ);
    localparam int MSB = WIDTH - 1;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               cin_q, cin_d, ovfl_q, ovfl_d, zero_q, zero_d;
    logic [NUM_REQ-1:0] gnt, owner_oh;
    logic [WIDTH-1:0]   cla_sum, res_val;
    logic               cla_ovfl, owner_ack;
    logic               cla_cout_unused;

    rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt)
    );

    cla16 #(.WIDTH(WIDTH)) u_cla (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .sum_o  (cla_sum),
        .cout_o (cla_cout_unused)
    );

    // b_q already holds B' (B inverted for subtract), so this is the add-form overflow rule.
    assign cla_ovfl = (a_q[MSB] == b_q[MSB]) && (cla_sum[MSB] != a_q[MSB]);

`ifdef CLA_SHARE_SCHED_SAT_EN
    assign res_val = !cla_ovfl ? cla_sum : (a_q[MSB] ? SAT_NEG : SAT_POS);
`else
    assign res_val = cla_sum;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are reset too, since the result bus must read zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NUM_REQ - 1);
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt[i]) begin
                        a_d     = req_a[i*WIDTH +: WIDTH];
                        b_d     = req_b[i*WIDTH +: WIDTH] ^ {WIDTH{req_sub[i]}};
                        cin_d   = req_sub[i];
                        owner_d = PW'(i);
                        ptr_d   = PW'(i);
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                sum_d   = res_val;
                ovfl_d  = cla_ovfl;
                zero_d  = (res_val == '0);
                state_d = RESP;
            end
            RESP: begin
                if (owner_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == PW'(i));
        end
        owner_ack = |(rsp_ready & owner_oh);
        req_ready = gnt;
        rsp_valid = (state_q == RESP) ? owner_oh : '0;
        busy      = (state_q != IDLE);
        rsp_sum   = sum_q;
        rsp_ovfl  = ovfl_q;
        rsp_zero  = zero_q;
    end

endmodule

// File: tb/tb_cla_share_sched.sv
// Self-checking bench for cla_share_sched: directed cases plus randomized
// traffic against a transaction-level arithmetic/arbitration model.
module tb_cla_share_sched;
    localparam int W = 16;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_sum;
    logic           rsp_ovfl, rsp_zero, busy;

    int checks   = 0;
    int failures = 0;
    int model_ptr;
    int g;

    logic [W-1:0] pa [N];
    logic [W-1:0] pb [N];
    logic         ps [N];

    always #5 clk = ~clk;

    cla_share_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_ovfl  (rsp_ovfl),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    // Returns {ovfl, result} from signed integer arithmetic on the requester's payload.
    function automatic logic [W:0] model_result(input int r);
        int sa, sb, res;
        logic ov;
        logic [W-1:0] val;
        sa  = int'($signed(pa[r]));
        sb  = int'($signed(pb[r]));
        res = ps[r] ? (sa - sb) : (sa + sb);
        ov  = (res > (2**(W-1)) - 1) || (res < -(2**(W-1)));
        val = W'(res);
`ifdef CLA_SHARE_SCHED_SAT_EN
        if (ov) val = pa[r][W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {ov, val};
    endfunction

    task automatic drive(input logic [N-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = pa[i];
            req_b[i*W +: W] = pb[i];
            req_sub[i]      = ps[i];
        end
    endtask

    // One complete operation from IDLE: accept, EXEC, RESP (held for 'hold' cycles), consume.
    task automatic txn(input logic [N-1:0] mask, input int hold, input string tag, output int gi);
        logic [W:0]   exp;
        logic [N-1:0] exp_oh;
        drive(mask);
        #1;
        gi     = model_grant(mask);
        exp_oh = N'(1) << gi;
        exp    = model_result(gi);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_oh));
        @(posedge clk); #1;
        model_ptr = gi;
        req_valid = mask & ~exp_oh;
        check({tag, "_exec_busy"}, 32'(busy), 32'd1);
        check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_exec_rspv"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_rspv"}, 32'(rsp_valid), 32'(exp_oh));
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp[W-1:0]));
        check({tag, "_ovfl"}, 32'(rsp_ovfl), 32'(exp[W]));
        check({tag, "_zero"}, 32'(rsp_zero), 32'(exp[W-1:0] == '0));
        check({tag, "_resp_ready"}, 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~exp_oh;
            @(posedge clk); #1;
            check({tag, "_hold_rspv"}, 32'(rsp_valid), 32'(exp_oh));
            check({tag, "_hold_sum"}, 32'(rsp_sum), 32'(exp[W-1:0]));
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = exp_oh;
        @(posedge clk); #1;
        rsp_ready = '0;
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_rspv"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            pa[i] = '0; pb[i] = '0; ps[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        check("rst_ovfl", 32'(rsp_ovfl), 32'd0);
        check("rst_zero", 32'(rsp_zero), 32'd0);
        rst_n     = 1'b1;
        model_ptr = N - 1;

        // Directed arithmetic cases; the held result is also compared with hand values.
        pa[0] = 16'h1234; pb[0] = 16'h0FFF; ps[0] = 1'b0;
        txn(2'b01, 0, "add", g);
        check("add_const", 32'(rsp_sum), 32'h2233);

        pa[1] = 16'h7FFF; pb[1] = 16'h0001; ps[1] = 1'b0;
        txn(2'b10, 0, "addovf", g);
        check("addovf_flag", 32'(rsp_ovfl), 32'd1);
`ifdef CLA_SHARE_SCHED_SAT_EN
        check("addovf_const", 32'(rsp_sum), 32'h7FFF);
`else
        check("addovf_const", 32'(rsp_sum), 32'h8000);
`endif

        pa[0] = 16'h0005; pb[0] = 16'h0005; ps[0] = 1'b1;
        txn(2'b01, 0, "subzero", g);
        check("subzero_const", 32'(rsp_zero), 32'd1);

        pa[0] = 16'h8000; pb[0] = 16'h0001; ps[0] = 1'b1;
        txn(2'b01, 0, "subovf", g);
        check("subovf_flag", 32'(rsp_ovfl), 32'd1);
`ifdef CLA_SHARE_SCHED_SAT_EN
        check("subovf_const", 32'(rsp_sum), 32'h8000);
`else
        check("subovf_const", 32'(rsp_sum), 32'h7FFF);
`endif

        // Fairness from reset with both requesters always valid: expect 0,1,0,1.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        model_ptr = N - 1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                pa[i] = W'($urandom); pb[i] = W'($urandom); ps[i] = 1'($urandom);
            end
            txn(2'b11, (k == 1) ? 5 : 0, "fair", g);
            check("fair_order", 32'(req_ready), (k % 2 == 0) ? 32'd2 : 32'd1);
        end

        // Reset while in EXEC right after a grant to requester 0.
        pa[0] = 16'h1111; pb[0] = 16'h2222; ps[0] = 1'b0;
        drive(2'b01);
        #1;
        check("mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        check("mid_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        model_ptr = N - 1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rspv", 32'(rsp_valid), 32'd0);
        check("mid_rst_sum", 32'(rsp_sum), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn(2'b11, 0, "post_rst", g);
        check("post_rst_grant0", 32'(g), 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       pa[i] = 16'h8000;
                    1:       pa[i] = 16'h7FFF;
                    default: pa[i] = W'($urandom);
                endcase
                pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : W'($urandom);
                ps[i] = 1'($urandom);
            end
            m = N'($urandom_range(1, (1 << N) - 1));
            txn(m, $urandom_range(0, 3), "rand", g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
